decode_issue_sched: RTL

DECODE_ISSUE_SCHED -- requirements
Module: decode_issue_sched

---
 rtl/decode_issue_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/decode_issue_sched.sv
// Decode-to-issue uop queue: accepts 1-2 uop decode groups into a circular FIFO and
// issues up to two uops per cycle from the head, throttling capability-class uops.
package decode_issue_sched_pkg;
  typedef enum logic [3:0] {
    UOP_INT_ALU      = 4'd0,
    UOP_ST_U8        = 4'd1,
    UOP_PACK_ADD_SAT = 4'd2,
    UOP_CAP_JUMP     = 4'd3,
    UOP_LINK         = 4'd4,
    UOP_LD_U8        = 4'd5
  } uop_tag_t;
endpackage

module decode_issue_sched
  import decode_issue_sched_pkg::*;
#(
  parameter int MAX_UOPS      = 2,
  parameter int DEPTH         = 8,
  parameter int CAP_PER_CYCLE = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      decode_valid_i,
  input  uop_tag_t                  decode_uop0_i,
  input  uop_tag_t                  decode_uop1_i,
  input  logic [1:0]                decode_uop_count_i,
  input  logic [MAX_UOPS-1:0]       decode_cap_i,
  output logic                      decode_ready_o,
  output logic                      issue_valid_o,
  output uop_tag_t                  issue_uop0_o,
  output uop_tag_t                  issue_uop1_o,
  output logic [1:0]                issue_count_o,
  output logic [MAX_UOPS-1:0]       issue_cap_o,
  input  logic                      rename_ready_i,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic [15:0]               stall_count_o,
  output logic [15:0]               cap_issued_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  uop_tag_t         r_tag_mem [DEPTH];
  logic [DEPTH-1:0] r_cap_mem;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [OW-1:0]    r_occ;
  logic [15:0]      r_stall_cnt;
  logic [15:0]      r_cap_cnt;

  logic [PW-1:0]    w_head_p1;
  logic [PW-1:0]    w_tail_p1;
  logic [OW-1:0]    w_free;
  logic             w_enq;
  logic [1:0]       w_enq_cnt;
  logic             w_deq;
  logic [1:0]       w_deq_cnt;
  logic             w_h0_cap;
  logic             w_h1_cap;
  logic [1:0]       w_cap_sum;
  logic [1:0]       w_issue_cnt;
  logic [1:0]       w_cap_cons;

  assign w_head_p1 = r_head + PW'(1);
  assign w_tail_p1 = r_tail + PW'(1);

  // Ready looks only at registered occupancy; a same-cycle dequeue never opens room.
  assign w_free         = OW'(DEPTH) - r_occ;
  assign decode_ready_o = (w_free >= OW'(2)) && !flush_i;

  assign w_enq     = decode_valid_i && decode_ready_o &&
                     ((decode_uop_count_i == 2'd1) || (decode_uop_count_i == 2'd2));
  assign w_enq_cnt = w_enq ? decode_uop_count_i : 2'd0;

  assign w_h0_cap  = r_cap_mem[r_head];
  assign w_h1_cap  = r_cap_mem[w_head_p1];
  assign w_cap_sum = {1'b0, w_h0_cap} + {1'b0, w_h1_cap};

  always_comb begin
    w_issue_cnt = 2'd0;
    if ((r_occ >= OW'(2)) && (w_cap_sum <= 2'(CAP_PER_CYCLE))) begin
      w_issue_cnt = 2'd2;
    end else if (r_occ != '0) begin
      w_issue_cnt = 2'd1;
    end
  end

  assign issue_valid_o = (r_occ != '0);
  assign issue_count_o = w_issue_cnt;
  assign issue_uop0_o  = (w_issue_cnt != 2'd0) ? r_tag_mem[r_head] : UOP_INT_ALU;
  assign issue_uop1_o  = (w_issue_cnt == 2'd2) ? r_tag_mem[w_head_p1] : UOP_INT_ALU;
  assign issue_cap_o   = {(w_issue_cnt == 2'd2) && w_h1_cap,
                          (w_issue_cnt != 2'd0) && w_h0_cap};

  // Flush wins over a same-cycle consume, so nothing is counted as issued then.
  assign w_deq      = issue_valid_o && rename_ready_i && !flush_i;
  assign w_deq_cnt  = w_deq ? w_issue_cnt : 2'd0;
  assign w_cap_cons = w_deq ? ({1'b0, issue_cap_o[0]} + {1'b0, issue_cap_o[1]}) : 2'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_stall_cnt <= '0;
      r_cap_cnt   <= '0;
    end else begin
      if (flush_i) begin
        r_head <= '0;
        r_tail <= '0;
        r_occ  <= '0;
      end else begin
        r_head <= r_head + PW'(w_deq_cnt);
        r_tail <= r_tail + PW'(w_enq_cnt);
        r_occ  <= r_occ + OW'(w_enq_cnt) - OW'(w_deq_cnt);
      end
      if (issue_valid_o && !rename_ready_i && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      r_cap_cnt <= r_cap_cnt + 16'(w_cap_cons);
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_tag_mem[r_tail] <= decode_uop0_i;
      r_cap_mem[r_tail] <= decode_cap_i[0];
      if (decode_uop_count_i == 2'd2) begin
        r_tag_mem[w_tail_p1] <= decode_uop1_i;
        r_cap_mem[w_tail_p1] <= decode_cap_i[1];
      end
    end
  end

  assign occupancy_o        = r_occ;
  assign stall_count_o      = r_stall_cnt;
  assign cap_issued_count_o = r_cap_cnt;

endmodule
